quad_encoder_counter: RTL and testbench
=======================================

# quad_encoder_counter

Parametrised quadrature-encoder front end: synchronises and debounces encoder channels A/B and the push switch, decodes rotation in x1/x2/x4 resolution, and maintains a WIDTH-bit position count with direction and error reporting. Sits between the board encoder pins and application logic such as LED indicators or menu state, replacing per-design hard-wired 3-bit counters.

## Interface
- `WIDTH`, 8: position counter width, in bits (≥2).
- `BOUNCE_LIMIT`, 100000: consecutive stable cycles required before a filtered input changes (≥2).
- `MODE`, 0: decode resolution. 0 = x1 (A rising only), 1 = x2 (A both edges), 2 = x4 (every A/B edge).
- `INVERT_DIR`, 0: 1 swaps the CW/CCW interpretation.
- `IDLE_AB`, 2'b11: reset value of the filtered {A,B} pair, matching the encoder detent level.

- `clk`  in  1: single clock domain.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enc_ch_a`  in  1: raw channel A, asynchronous.
- `enc_ch_b`  in  1: raw channel B, asynchronous.
- `enc_sw`  in  1: raw push switch, active-high, asynchronous.
- `count`  out  WIDTH: position counter, unsigned.
- `dir`  out  1: direction of the last valid step. 1 = CW, 0 = CCW.
- `step_pulse`  out  1: one-cycle pulse for each counted step.
- `sw_press`  out  1: one-cycle pulse on the filtered switch rising edge.
- `err`  out  1: one-cycle pulse when A and B change in the same cycle.

## Operation
- **Synchroniser:** each raw input passes through a 2-flop synchroniser.
- **Debounce, per channel:**
  - A stability counter of ceil(log2(BOUNCE_LIMIT)) bits increments each cycle the synced value ≠ the filtered value. It clears on any cycle they are equal.
  - When the counter is at BOUNCE_LIMIT-1 and the values still differ, the filtered value takes the synced value and the counter clears.
- **Decode:**
  - Registers `prev_ab` (filtered {A,B} of the previous cycle) and `cur_ab`.
  - CW sequence is 00→10→11→01→00 (A leads B).
  - x4: every single-bit change is a step. Direction comes from the sequence table.
  - x2: only changes of A count. Direction is CW when new A ≠ B.
  - x1: only A rising counts. Direction is CW when B = 0.
  - INVERT_DIR flips the direction sense after decode.
- **Illegal transition:** both bits change in one cycle. Pulse `err`. No count change. `dir` is unchanged.
- **Counting:**
  - CW adds 1 to `count`, CCW subtracts 1.
  - Arithmetic is modulo 2^WIDTH by default; see Configuration.
  - `dir` updates on every valid step.
- **Switch:** a filtered `enc_sw` 0→1 edge clears `count` to 0 and pulses `sw_press`. `dir` is unchanged.
  - If a step and a switch edge occur in the same cycle, the clear wins. `step_pulse` still asserts and `dir` still updates.
- **Reset values:**
  - `count`=0, `dir`=1, `step_pulse`=0, `sw_press`=0, `err`=0.
  - Synchronisers and filtered A/B reset to IDLE_AB. Synchroniser and filtered switch reset to 0.
  - All stability counters reset to 0.
  - Assertion mid-operation aborts any pending debounce immediately.

## Timing
- A raw change held stable appears on the filtered value exactly 2+BOUNCE_LIMIT cycles later.
- `count`, `dir`, `step_pulse`, `err` and `sw_press` are registered. They update one cycle after the filtered change: 3+BOUNCE_LIMIT cycles total from the raw edge.
- A glitch shorter than BOUNCE_LIMIT synced cycles produces no output activity.
- Pulses are exactly one cycle wide. Back-to-back steps on consecutive cycles each produce a pulse.

## Configuration
- `ENC_CLAMP_EN` defined: `count` saturates.
  - CW at 2^WIDTH-1 holds. CCW at 0 holds.
  - `step_pulse` and `dir` still update.
- `ENC_CLAMP_EN` undefined: `count` wraps (2^WIDTH-1 +1 → 0, 0 −1 → 2^WIDTH-1).

## Test plan
All scenarios use BOUNCE_LIMIT=4, WIDTH=4.
- **x4 rotation:** MODE=2; drive one full CW cycle 11→01→00→10→11, each state held 10 cycles → `count`=4, four `step_pulse`, `dir`=1; first pulse exactly 7 cycles after the raw edge.
- **x1 rotation:** MODE=0; three CCW detent cycles → `count`=13 (wrap from 0), three pulses, `dir`=0; with `ENC_CLAMP_EN` → `count`=0, three pulses.
- **Bounce rejection:** toggle `enc_ch_a` with a 3-cycle-high/2-cycle-low pattern for 40 cycles, then settle → no pulse during the toggling, exactly one step after settling.
- **Illegal transition:** force filtered {A,B} 11→00 in one cycle → `err` pulses once, `count` and `dir` unchanged.
- **Switch clear:** with `count`=9, press `enc_sw`; separately, coincide a switch edge with a CW step → `sw_press` pulses and `count`=0 both times, `step_pulse` asserted in the coincident case.
- **Reset mid-debounce:** assert `rst_n`=0 two cycles into an A change → all outputs return to reset values asynchronously; no step occurs after release.

Source files
------------

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter
// Quadrature-encoder front end: two-flop synchronisers, per-channel debounce
// filters, x1/x2/x4 decode and a WIDTH-bit position counter with direction,
// step, switch-press and illegal-transition reporting.
// Optional build macro: ENC_CLAMP_EN -- count saturates at 0 and 2^WIDTH-1
// instead of wrapping.
module quad_encoder_counter #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned BOUNCE_LIMIT = 100000,
    parameter int unsigned MODE         = 0,
    parameter int unsigned INVERT_DIR   = 0,
    parameter logic [1:0]  IDLE_AB      = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_ch_a,
    input  logic             enc_ch_b,
    input  logic             enc_sw,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step_pulse,
    output logic             sw_press,
    output logic             err
);

    localparam int unsigned       STAB_W   = $clog2(BOUNCE_LIMIT);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(BOUNCE_LIMIT - 1);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    // Channel bit order throughout: {A, B, SW}
    localparam logic [2:0]        RAW_IDLE = {IDLE_AB, 1'b0};
    localparam logic              INV      = (INVERT_DIR != 0);

    logic [2:0]        sync_q1;
    logic [2:0]        sync_q2;
    logic [2:0]        filt_q;
    logic [STAB_W-1:0] stab_q [3];
    logic [1:0]        prev_ab;
    logic              prev_sw;
    logic [1:0]        cur_ab;
    logic [1:0]        delta_ab;
    logic              sw_rise;
    logic              step_now;
    logic              cw_now;
    logic              illegal_now;
    logic [WIDTH-1:0]  count_step;

    // Two-flop synchronisers for the three asynchronous pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= RAW_IDLE;
            sync_q2 <= RAW_IDLE;
        end else begin
            sync_q1 <= {enc_ch_a, enc_ch_b, enc_sw};
            sync_q2 <= sync_q1;
        end
    end

    // Per-channel debounce: accept a new level only after BOUNCE_LIMIT differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= RAW_IDLE;
            for (int unsigned i = 0; i < 3; i++) begin
                stab_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync_q2[i] == filt_q[i]) begin
                    stab_q[i] <= '0;
                end else if (stab_q[i] == STAB_MAX) begin
                    filt_q[i] <= sync_q2[i];
                    stab_q[i] <= '0;
                end else begin
                    stab_q[i] <= stab_q[i] + STAB_ONE;
                end
            end
        end
    end

    // Previous-cycle copies of the filtered levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab <= IDLE_AB;
            prev_sw <= 1'b0;
        end else begin
            prev_ab <= filt_q[2:1];
            prev_sw <= filt_q[0];
        end
    end

    assign cur_ab   = filt_q[2:1];
    assign delta_ab = cur_ab ^ prev_ab;
    assign sw_rise  = filt_q[0] & ~prev_sw;

    // Classify the filtered A/B transition for the selected resolution
    always_comb begin
        step_now    = 1'b0;
        cw_now      = 1'b0;
        illegal_now = (delta_ab == 2'b11);
        if (MODE == 0) begin
            step_now = (delta_ab == 2'b10) && cur_ab[1];
            cw_now   = ~cur_ab[0];
        end else if (MODE == 1) begin
            step_now = (delta_ab == 2'b10);
            cw_now   = cur_ab[1] ^ cur_ab[0];
        end else begin
            // A single-bit move is CW exactly when new A differs from old B
            step_now = (delta_ab == 2'b10) || (delta_ab == 2'b01);
            cw_now   = cur_ab[1] ^ prev_ab[0];
        end
        cw_now = cw_now ^ INV;
    end

    // Counter value after one step in the decoded direction
    always_comb begin
        count_step = count;
`ifdef ENC_CLAMP_EN
        if (cw_now) begin
            count_step = (count == '1) ? count : count + CNT_ONE;
        end else begin
            count_step = (count == '0) ? count : count - CNT_ONE;
        end
`else
        count_step = cw_now ? count + CNT_ONE : count - CNT_ONE;
`endif
    end

    // Registered outputs; a switch press clears the count even on a step cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            dir        <= 1'b1;
            step_pulse <= 1'b0;
            sw_press   <= 1'b0;
            err        <= 1'b0;
        end else begin
            step_pulse <= step_now;
            sw_press   <= sw_rise;
            err        <= illegal_now;
            if (step_now) begin
                dir <= cw_now;
            end
            if (sw_rise) begin
                count <= '0;
            end else if (step_now) begin
                count <= count_step;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Testbench for quad_encoder_counter: four instances (x1, x2, x4, x4 inverted)
// share the raw pins and are checked against a sequence-position model.
module tb_quad_encoder_counter;

    localparam int W   = 4;
    localparam int BL  = 4;
    localparam int N   = 4;
    localparam int LAT = 3 + BL;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic enc_ch_a = 1'b1;
    logic enc_ch_b = 1'b1;
    logic enc_sw   = 1'b0;

    logic [W-1:0] count_o [N];
    logic         dir_o   [N];
    logic         step_o  [N];
    logic         swp_o   [N];
    logic         err_o   [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        quad_encoder_counter #(
            .WIDTH       (W),
            .BOUNCE_LIMIT(BL),
            .MODE        ((gi == 0) ? 0 : ((gi == 1) ? 1 : 2)),
            .INVERT_DIR  ((gi == 3) ? 1 : 0),
            .IDLE_AB     (2'b11)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .enc_ch_a  (enc_ch_a),
            .enc_ch_b  (enc_ch_b),
            .enc_sw    (enc_sw),
            .count     (count_o[gi]),
            .dir       (dir_o[gi]),
            .step_pulse(step_o[gi]),
            .sw_press  (swp_o[gi]),
            .err       (err_o[gi])
        );
    end

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pulse monitor: cumulative pulse counts and cycle of latest pulse
    int cyc = 0;
    int n_step    [N] = '{default: 0};
    int n_err     [N] = '{default: 0};
    int n_sw      [N] = '{default: 0};
    int last_step [N] = '{default: 0};
    int last_sw   [N] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (step_o[i] === 1'b1) begin
                n_step[i]++;
                last_step[i] = cyc;
            end
            if (err_o[i] === 1'b1) n_err[i]++;
            if (swp_o[i] === 1'b1) begin
                n_sw[i]++;
                last_sw[i] = cyc;
            end
        end
    end

    // Reference model: position along the 4-state CW cycle 00,10,11,01
    int         mode_of [N] = '{0, 1, 2, 2};
    bit         inv_of  [N] = '{0, 0, 0, 1};
    int         m_pos   [N] = '{default: 0};
    bit         m_dir   [N] = '{default: 1};
    int         m_steps [N] = '{default: 0};
    int         m_errs = 0;
    int         m_sws  = 0;
    logic [1:0] m_ab   = 2'b11;
    logic       m_sw   = 1'b0;

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int next_pos(input int pos, input bit cw);
`ifdef ENC_CLAMP_EN
        if (cw) return (pos == (1 << W) - 1) ? pos : pos + 1;
        return (pos == 0) ? 0 : pos - 1;
`else
        return (pos + (cw ? 1 : (1 << W) - 1)) % (1 << W);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pos[i] = 0;
            m_dir[i] = 1'b1;
        end
        m_ab = 2'b11;
        m_sw = 1'b0;
    endtask

    task automatic model_event(input logic [1:0] new_ab, input logic new_sw);
        int d;
        bit a_changed;
        bit a_rose;
        bit counts;
        bit cw;
        d         = (gidx(new_ab) - gidx(m_ab) + 4) % 4;
        a_changed = (new_ab[1] != m_ab[1]);
        a_rose    = new_ab[1] && !m_ab[1];
        if (d == 2) begin
            m_errs++;
        end else if (d != 0) begin
            for (int i = 0; i < N; i++) begin
                counts = (mode_of[i] == 2) || (mode_of[i] == 1 && a_changed) ||
                         (mode_of[i] == 0 && a_rose);
                if (counts) begin
                    cw         = (d == 1) ^ inv_of[i];
                    m_dir[i]   = cw;
                    m_pos[i]   = next_pos(m_pos[i], cw);
                    m_steps[i]++;
                end
            end
        end
        if (new_sw && !m_sw) begin
            m_sws++;
            for (int i = 0; i < N; i++) m_pos[i] = 0;
        end
        m_ab = new_ab;
        m_sw = new_sw;
    endtask

    // Caller is at a negedge; drive raw pins, update model, hold
    task automatic apply(input logic a, input logic b, input logic sw, input int hold);
        enc_ch_a = a;
        enc_ch_b = b;
        enc_sw   = sw;
        model_event({a, b}, sw);
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enc_ch_a = 1'b1;
        enc_ch_b = 1'b1;
        enc_sw   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int s0 [N];
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({count_o[i], dir_o[i], step_o[i], swp_o[i], err_o[i]} !== {4'h0, 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL reset_values[%0d]: got cnt=%0d dir=%b step=%b sw=%b err=%b expected cnt=0 dir=1 pulses=0",
                         i, count_o[i], dir_o[i], step_o[i], swp_o[i], err_o[i]);
            end
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) s0[i] = n_step[i] + n_err[i] + n_sw[i];
        repeat (12) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_step[i] + n_err[i] + n_sw[i] != s0[i] || count_o[i] !== '0) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: got pulses=%0d cnt=%0d expected pulses=0 cnt=0",
                         i, n_step[i] + n_err[i] + n_sw[i] - s0[i], count_o[i]);
            end
        end
    endtask

    task automatic test_x4_rotation();
        logic [1:0] seq [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
        int s0 [N];
        int ms [N];
        int c0;
        int first;
        do_reset();
        for (int i = 0; i < N; i++) begin
            s0[i] = n_step[i];
            ms[i] = m_steps[i];
        end
        c0 = cyc;
        apply(seq[0][1], seq[0][0], 1'b0, 10);
        first = last_step[2];
        for (int k = 1; k < 4; k++) apply(seq[k][1], seq[k][0], 1'b0, 10);
        checks++;
        if (n_step[2] - s0[2] < 1 || first - c0 != LAT) begin
            errors++;
            $display("FAIL x4_first_latency: got %0d cycles expected %0d", first - c0, LAT);
        end
        checks++;
        if (count_o[2] !== 4'd4 || dir_o[2] !== 1'b1 || n_step[2] - s0[2] != 4) begin
            errors++;
            $display("FAIL x4_cycle: got cnt=%0d dir=%b steps=%0d expected cnt=4 dir=1 steps=4",
                     count_o[2], dir_o[2], n_step[2] - s0[2]);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (count_o[i] !== W'(m_pos[i]) || dir_o[i] !== m_dir[i] ||
                n_step[i] - s0[i] != m_steps[i] - ms[i]) begin
                errors++;
                $display("FAIL rotation_cw[%0d]: got cnt=%0d dir=%b steps=%0d expected cnt=%0d dir=%b steps=%0d",
                         i, count_o[i], dir_o[i], n_step[i] - s0[i], m_pos[i], m_dir[i], m_steps[i] - ms[i]);
            end
        end
    endtask

    task automatic test_x1_rotation();
        logic [1:0] seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};
        int s0 [N];
        int ms [N];
        int exp_x1;
`ifdef ENC_CLAMP_EN
        exp_x1 = 0;
`else
        exp_x1 = 13;
`endif
        do_reset();
        for (int i = 0; i < N; i++) begin
            s0[i] = n_step[i];
            ms[i] = m_steps[i];
        end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) apply(seq[k][1], seq[k][0], 1'b0, 10);
        end
        checks++;
        if (count_o[0] !== W'(exp_x1) || dir_o[0] !== 1'b0 || n_step[0] - s0[0] != 3) begin
            errors++;
            $display("FAIL x1_ccw: got cnt=%0d dir=%b steps=%0d expected cnt=%0d dir=0 steps=3",
                     count_o[0], dir_o[0], n_step[0] - s0[0], exp_x1);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (count_o[i] !== W'(m_pos[i]) || dir_o[i] !== m_dir[i] ||
                n_step[i] - s0[i] != m_steps[i] - ms[i]) begin
                errors++;
                $display("FAIL rotation_ccw[%0d]: got cnt=%0d dir=%b steps=%0d expected cnt=%0d dir=%b steps=%0d",
                         i, count_o[i], dir_o[i], n_step[i] - s0[i], m_pos[i], m_dir[i], m_steps[i] - ms[i]);
            end
        end
    endtask

    task automatic test_bounce();
        int s0 [N];
        int ms [N];
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 10);
        for (int i = 0; i < N; i++) s0[i] = n_step[i] + n_err[i];
        for (int r = 0; r < 8; r++) begin
            enc_ch_a = 1'b1;
            repeat (3) @(negedge clk);
            enc_ch_a = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_step[i] + n_err[i] != s0[i] || count_o[i] !== W'(m_pos[i])) begin
                errors++;
                $display("FAIL bounce_quiet[%0d]: got pulses=%0d cnt=%0d expected pulses=0 cnt=%0d",
                         i, n_step[i] + n_err[i] - s0[i], count_o[i], m_pos[i]);
            end
            s0[i] = n_step[i];
            ms[i] = m_steps[i];
        end
        apply(1'b1, 1'b1, 1'b0, 12);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_step[i] - s0[i] != 1 || m_steps[i] - ms[i] != 1 ||
                count_o[i] !== W'(m_pos[i]) || dir_o[i] !== m_dir[i]) begin
                errors++;
                $display("FAIL bounce_settle[%0d]: got steps=%0d cnt=%0d dir=%b expected steps=1 cnt=%0d dir=%b",
                         i, n_step[i] - s0[i], count_o[i], dir_o[i], m_pos[i], m_dir[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int se [N];
        int ss [N];
        int me;
        int ms [N];
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 10);
        for (int i = 0; i < N; i++) begin
            se[i] = n_err[i];
            ss[i] = n_step[i];
            ms[i] = m_steps[i];
        end
        me = m_errs;
        apply(1'b1, 1'b0, 1'b0, 10);
        apply(1'b1, 1'b1, 1'b0, 10);
        apply(1'b0, 1'b0, 1'b0, 10);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_err[i] - se[i] != 2 || m_errs - me != 2 || n_step[i] - ss[i] != m_steps[i] - ms[i] ||
                count_o[i] !== W'(m_pos[i]) || dir_o[i] !== m_dir[i]) begin
                errors++;
                $display("FAIL illegal[%0d]: got errs=%0d steps=%0d cnt=%0d dir=%b expected errs=2 steps=%0d cnt=%0d dir=%b",
                         i, n_err[i] - se[i], n_step[i] - ss[i], count_o[i], dir_o[i],
                         m_steps[i] - ms[i], m_pos[i], m_dir[i]);
            end
        end
    endtask

    task automatic test_switch();
        logic [1:0] seq [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
        int ss [N];
        int sw0 [N];
        do_reset();
        for (int k = 0; k < 9; k++) apply(seq[k % 4][1], seq[k % 4][0], 1'b0, 10);
        checks++;
        if (count_o[2] !== 4'd9) begin
            errors++;
            $display("FAIL switch_precount: got cnt=%0d expected 9", count_o[2]);
        end
        for (int i = 0; i < N; i++) sw0[i] = n_sw[i];
        apply(m_ab[1], m_ab[0], 1'b1, 10);
        apply(m_ab[1], m_ab[0], 1'b0, 10);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_sw[i] - sw0[i] != 1 || count_o[i] !== '0) begin
                errors++;
                $display("FAIL switch_clear[%0d]: got presses=%0d cnt=%0d expected presses=1 cnt=0",
                         i, n_sw[i] - sw0[i], count_o[i]);
            end
        end
        apply(1'b0, 1'b0, 1'b0, 10);
        for (int i = 0; i < N; i++) begin
            ss[i]  = n_step[i];
            sw0[i] = n_sw[i];
        end
        apply(1'b1, 1'b0, 1'b1, 10);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_step[i] - ss[i] != 1 || n_sw[i] - sw0[i] != 1 || last_step[i] != last_sw[i] ||
                count_o[i] !== '0 || dir_o[i] !== m_dir[i]) begin
                errors++;
                $display("FAIL switch_coincident[%0d]: got steps=%0d presses=%0d cnt=%0d dir=%b expected steps=1 presses=1 same cycle cnt=0 dir=%b",
                         i, n_step[i] - ss[i], n_sw[i] - sw0[i], count_o[i], dir_o[i], m_dir[i]);
            end
        end
        apply(1'b1, 1'b0, 1'b0, 10);
    endtask

    task automatic test_reset_mid_debounce();
        int ss [N];
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 10);
        enc_ch_a = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({count_o[i], dir_o[i], step_o[i], swp_o[i], err_o[i]} !== {4'h0, 1'b1, 3'b000}) begin
                errors++;
                $display("FAIL async_reset[%0d]: got cnt=%0d dir=%b step=%b sw=%b err=%b expected cnt=0 dir=1 pulses=0",
                         i, count_o[i], dir_o[i], step_o[i], swp_o[i], err_o[i]);
            end
        end
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) ss[i] = n_step[i];
        repeat (15) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_step[i] != ss[i] || count_o[i] !== '0 || dir_o[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_abort[%0d]: got steps=%0d cnt=%0d dir=%b expected steps=0 cnt=0 dir=1",
                         i, n_step[i] - ss[i], count_o[i], dir_o[i]);
            end
        end
    endtask

    task automatic test_random();
        int ss [N];
        int se [N];
        int sw0 [N];
        int ms [N];
        int me;
        int msw;
        int gs [N];
        int r;
        int g;
        do_reset();
        for (int i = 0; i < N; i++) begin
            ss[i]  = n_step[i];
            se[i]  = n_err[i];
            sw0[i] = n_sw[i];
            ms[i]  = m_steps[i];
        end
        me  = m_errs;
        msw = m_sws;
        for (int e = 0; e < 80; e++) begin
            r = $urandom_range(0, 9);
            if (r == 1) begin
                for (int i = 0; i < N; i++) gs[i] = n_step[i] + n_err[i];
                g = $urandom_range(1, BL - 1);
                enc_ch_a = ~m_ab[1];
                repeat (g) @(negedge clk);
                enc_ch_a = m_ab[1];
                repeat (BL + 6) @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (n_step[i] + n_err[i] != gs[i]) begin
                        errors++;
                        $display("FAIL glitch[%0d] event %0d: got pulses=%0d expected 0 (width %0d)",
                                 i, e, n_step[i] + n_err[i] - gs[i], g);
                    end
                end
            end else begin
                case (r)
                    0:       apply(~m_ab[1], ~m_ab[0], m_sw, $urandom_range(BL + 4, BL + 8));
                    2:       apply(m_ab[1], m_ab[0], ~m_sw, $urandom_range(BL + 4, BL + 8));
                    3, 4, 5, 6: apply(~m_ab[1], m_ab[0], m_sw, $urandom_range(BL + 4, BL + 8));
                    default: apply(m_ab[1], ~m_ab[0], m_sw, $urandom_range(BL + 4, BL + 8));
                endcase
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (count_o[i] !== W'(m_pos[i]) || dir_o[i] !== m_dir[i]) begin
                        errors++;
                        $display("FAIL random[%0d] event %0d: got cnt=%0d dir=%b expected cnt=%0d dir=%b",
                                 i, e, count_o[i], dir_o[i], m_pos[i], m_dir[i]);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (n_step[i] - ss[i] != m_steps[i] - ms[i] || n_err[i] - se[i] != m_errs - me ||
                n_sw[i] - sw0[i] != m_sws - msw) begin
                errors++;
                $display("FAIL random_totals[%0d]: got steps=%0d errs=%0d presses=%0d expected steps=%0d errs=%0d presses=%0d",
                         i, n_step[i] - ss[i], n_err[i] - se[i], n_sw[i] - sw0[i],
                         m_steps[i] - ms[i], m_errs - me, m_sws - msw);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_x4_rotation();
        test_x1_rotation();
        test_bounce();
        test_illegal();
        test_switch();
        test_reset_mid_debounce();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
